// File: rtl/uart_tx_tick_pkg.sv
// rtl/uart_tx_tick_pkg.sv - shared types and constants for the tick-driven UART transmitter
package uart_tx_tick_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        START = 2'b01,
        DATA  = 2'b10,
        STOP  = 2'b11
    } tx_state_e;

    localparam int DEF_DATA_BITS  = 8;
    localparam int DEF_OVERSAMPLE = 16;
    localparam int DEF_SB_TICK    = 16;

    // Tick counter divisor: 50 MHz clock, 16x oversampling of 19200 baud, rounded to nearest.
    localparam int CLK_HZ   = 50_000_000;
    localparam int BAUD     = 19_200;
    localparam int BAUD_DIV = (CLK_HZ + 8 * BAUD) / (16 * BAUD);

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/uart_tx_tick_baud.sv
// rtl/uart_tx_tick_baud.sv - free-running mod-DIV counter producing a one-cycle tick
// Ports: clk, reset (async active-low), o_tick (high one clk every DIV clks).
module uart_tx_tick_baud
    import uart_tx_tick_pkg::*;
#(
    parameter int DIV = BAUD_DIV
) (
    input  logic clk,
    input  logic reset,
    output logic o_tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] L_LAST = CW'(DIV - 1);

    logic [CW-1:0] r_cnt;
    logic          r_tick;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else begin
            r_tick <= (r_cnt == L_LAST);
            if (r_cnt == L_LAST) r_cnt <= '0;
            else                 r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tick = r_tick;

endmodule

// File: rtl/uart_tx_top.sv
// rtl/uart_tx_top.sv - tick counter feeding the UART transmitter
// Ports: clk, reset (async active-low), tx_start, din, tx, tx_busy, tx_done_tick.
module uart_tx_top
    import uart_tx_tick_pkg::*;
#(
    parameter int DATA_BITS = DEF_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tx_start,
    input  logic [DATA_BITS-1:0] din,
    output logic                 tx,
    output logic                 tx_busy,
    output logic                 tx_done_tick
);

    logic w_tick;

    uart_tx_tick_baud #(.DIV(BAUD_DIV)) u_baud (
        .clk    (clk),
        .reset  (reset),
        .o_tick (w_tick)
    );

    uart_tx_tick #(
        .DATA_BITS  (DATA_BITS),
        .SB_TICK    (DEF_SB_TICK),
        .OVERSAMPLE (DEF_OVERSAMPLE)
    ) u_tx (
        .clk          (clk),
        .reset        (reset),
        .s_tick       (w_tick),
        .tx_start     (tx_start),
        .din          (din),
        .tx           (tx),
        .tx_busy      (tx_busy),
        .tx_done_tick (tx_done_tick)
    );

endmodule

// File: rtl/uart_tx_tick.sv
// rtl/uart_tx_tick.sv - UART transmitter clocked by an external oversampling strobe
// Ports: clk, reset (async active-low), s_tick (oversample strobe), tx_start (request, IDLE only),
//        din (byte latched on accept), tx (serial line, idle high), tx_busy, tx_done_tick (1-clk pulse).
module uart_tx_tick
    import uart_tx_tick_pkg::*;
#(
    parameter int DATA_BITS  = DEF_DATA_BITS,
    parameter int SB_TICK    = DEF_SB_TICK,
    parameter int OVERSAMPLE = DEF_OVERSAMPLE
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 s_tick,
    input  logic                 tx_start,
    input  logic [DATA_BITS-1:0] din,
    output logic                 tx,
    output logic                 tx_busy,
    output logic                 tx_done_tick
);

    localparam int SW = $clog2(max2(OVERSAMPLE, SB_TICK));
    localparam int NW = $clog2(DATA_BITS);
    localparam logic [SW-1:0] L_OS_LAST = SW'(OVERSAMPLE - 1);
    localparam logic [SW-1:0] L_SB_LAST = SW'(SB_TICK - 1);
    localparam logic [NW-1:0] L_N_LAST  = NW'(DATA_BITS - 1);

    tx_state_e            r_state;
    logic [SW-1:0]        r_s_cnt;
    logic [NW-1:0]        r_n_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_tx;
    logic                 r_done;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_s_cnt <= '0;
            r_n_cnt <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_tx <= 1'b1;
                    if (tx_start) begin
                        r_shift <= din;
                        r_s_cnt <= '0;
                        r_state <= START;
                        r_tx    <= 1'b0;    // start bit appears on the accepting edge
                    end
                end
                START: begin
                    if (s_tick) begin
                        if (r_s_cnt == L_OS_LAST) begin
                            r_s_cnt <= '0;
                            r_n_cnt <= '0;
                            r_state <= DATA;
                            r_tx    <= r_shift[0];
                        end else begin
                            r_s_cnt <= r_s_cnt + 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (s_tick) begin
                        if (r_s_cnt == L_OS_LAST) begin
                            r_s_cnt <= '0;
                            r_shift <= r_shift >> 1;
                            if (r_n_cnt == L_N_LAST) begin
                                r_state <= STOP;
                                r_tx    <= 1'b1;
                            end else begin
                                r_n_cnt <= r_n_cnt + 1'b1;
                                // bit 1 is the one that lands in bit 0 after this shift
                                r_tx    <= r_shift[1];
                            end
                        end else begin
                            r_s_cnt <= r_s_cnt + 1'b1;
                        end
                    end
                end
                STOP: begin
                    r_tx <= 1'b1;
                    if (s_tick) begin
                        if (r_s_cnt == L_SB_LAST) begin
                            r_s_cnt <= '0;
                            r_state <= IDLE;
                            r_done  <= 1'b1;
                        end else begin
                            r_s_cnt <= r_s_cnt + 1'b1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign tx           = r_tx;
    assign tx_busy      = (r_state != IDLE);
    assign tx_done_tick = r_done;

endmodule

// File: doc/uart_tx_tick.md
Name: uart_tx_tick

Overview:
- Serial UART transmitter, 8N1 by default.
- Sits directly downstream of the tick-generating counter: it consumes that counter's single-cycle tick as a 16x oversampling strobe (s_tick) and shifts out one parallel byte per request.
- Sends a start bit, DATA_BITS data bits LSB first, then a stop bit. Reports busy status and a one-cycle completion pulse.

Parameters:
- DATA_BITS, 8, number of data bits per frame (legal range 5..8).
- SB_TICK, 16, s_tick count for the stop bit (16 = 1 stop bit, 24 = 1.5, 32 = 2).
- OVERSAMPLE, 16, s_tick count per start bit and per data bit.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- s_tick  in  1  oversampling strobe; each clk cycle it is high counts as one tick.
- tx_start  in  1  transmit request, sampled in IDLE only.
- din  in  DATA_BITS  byte to send, latched on the accepted tx_start cycle.
- tx  out  1  serial line; idle high, registered.
- tx_busy  out  1  high while a frame is in progress (state != IDLE).
- tx_done_tick  out  1  one-clk pulse after the stop bit completes.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, tx=1, tx_busy=0, tx_done_tick=0, internal tick/bit/shift counters all zero. A reset mid-frame aborts the frame immediately. No done pulse is produced. Operation resumes on the first clk edge after reset returns to 1.
- FSM states: IDLE, START, DATA, STOP. State, counters, shift register and tx are all registered.
- Tick counter s_cnt: width clog2(max(OVERSAMPLE, SB_TICK)). Bit counter n_cnt: width clog2(DATA_BITS).
- IDLE:
  - tx=1.
  - When tx_start=1: latch din into shift reg, s_cnt=0, go to START. tx goes to 0 on that same edge (no extra latency). tx_busy rises on that edge.
  - When tx_start=0: stay in IDLE.
- START:
  - tx=0.
  - On each s_tick: if s_cnt==OVERSAMPLE-1, then s_cnt=0, n_cnt=0, go to DATA, tx=shift[0]. Otherwise s_cnt+1.
- DATA:
  - tx=shift[0].
  - On s_tick with s_cnt==OVERSAMPLE-1: s_cnt=0 and shift right by one.
    - If n_cnt==DATA_BITS-1: go to STOP, tx=1.
    - Otherwise: n_cnt+1, tx=next bit.
  - Other s_tick: s_cnt+1.
- STOP:
  - tx=1.
  - On s_tick with s_cnt==SB_TICK-1: go to IDLE, tx_done_tick=1 for exactly that next cycle (the first IDLE cycle), tx_busy falls.
- Cycles with s_tick=0 change nothing except accepting tx_start in IDLE.
- tx_start while busy: ignored. din changes while busy: ignored (the byte was latched at acceptance).
- Back-to-back: tx_start=1 in the cycle tx_done_tick=1 is accepted. The next START begins with no idle gap beyond the stop bit.
- s_tick held high for k consecutive cycles counts as k ticks. Upstream must deliver single-cycle pulses.
- Frame duration: (OVERSAMPLE*(1+DATA_BITS)+SB_TICK) ticks.
- Counters never wrap: they are cleared on each bit boundary.

Decomposition:
- Shared package holds:
  - state encoding localparams (IDLE=2'b00, START=2'b01, DATA=2'b10, STOP=2'b11);
  - default OVERSAMPLE/SB_TICK constants;
  - the baud-divisor constant for the tick counter (e.g. 50 MHz / (16*19200) ≈ 163).
- No internal sub-module: the tick source is the existing counter block, instantiated beside this one at the integration level (its tick drives s_tick).
- A thin top-level wrapper, uart_tx_top, instantiates both.

Test Plan:
- Reset then idle, s_tick every 4 clk, tx_start=0 for 1000 clk -> tx=1, tx_busy=0, tx_done_tick never asserted.
- din=8'hA5, one-cycle tx_start, s_tick every 4 clk:
  - tx sequence 0,1,0,1,0,0,1,0,1,1, each bit held 64 clk;
  - tx_busy high for 640 clk;
  - single tx_done_tick exactly 640 clk after tx_start edge.
- tx_start pulsed again 100 clk into the frame with din=8'hFF -> ignored; frame still carries 8'hA5; only one done pulse.
- Back-to-back: din=8'h00 then 8'hFF, tx_start asserted in the tx_done_tick cycle -> second start bit begins immediately after the first stop bit; two done pulses 640 clk apart.
- reset driven low mid-DATA (bit 3) -> tx=1 and tx_busy=0 asynchronously, no done pulse. After release, a new 8'h3C frame transmits correctly.
- SB_TICK=32, DATA_BITS=7, din=7'h55 -> stop bit lasts 32 ticks; frame = 160 ticks; tx_done_tick 640 clk after start with s_tick every 4 clk.
